uart_rx: RTL

Serial receiver that deserialises the tester's incoming UART line into bytes for the command FSM. Each valid frame yields a parallel byte on `uart_data` plus a one-cycle `uart_push` strobe, which drive the FSM's `i_uart_data` / `uart_push` inputs directly. Format is fixed 8N1, LSB first, with the bit period set by a clock-divider parameter. Malformed frames are flagged and never presented to the FSM.

---
 rtl/uart_rx.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with a 2-FF input synchronizer and centre-of-bit sampling.
// A stop bit that samples low raises frame_err and parks in BREAK until the line goes high again.
module uart_rx #(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       rx,
  output logic [7:0] uart_data,
  output logic       uart_push,
  output logic       frame_err,
  output logic       rx_active
);

  localparam logic [15:0] HALF   = 16'(CLK_DIV / 2);
  localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [2:0]  r_bitcnt;
  logic [15:0] r_clkcnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_push;
  logic        r_ferr;
  logic        r_active;
  logic        w_rxs;

  assign w_rxs     = r_sync2;
  assign uart_data = r_data;
  assign uart_push = r_push;
  assign frame_err = r_ferr;
  assign rx_active = r_active;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state  <= S_IDLE;
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_bitcnt <= 3'd0;
      r_clkcnt <= 16'd0;
      r_shift  <= 8'd0;
      r_data   <= 8'd0;
      r_push   <= 1'b0;
      r_ferr   <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_push  <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clkcnt <= 16'd0;
          if (!w_rxs) begin
            r_state  <= S_START;
            r_active <= 1'b1;
          end
        end
        S_START: begin
          if (r_clkcnt == HALF) begin
            r_clkcnt <= 16'd0;
            if (!w_rxs) begin
              r_bitcnt <= 3'd0;
              r_state  <= S_DATA;
            end else begin
              // Start bit gone by mid-bit: a glitch, not a frame.
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end
          end else begin
            r_clkcnt <= r_clkcnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_clkcnt == DIV_M1) begin
            r_clkcnt          <= 16'd0;
            r_shift[r_bitcnt] <= w_rxs;
            r_bitcnt          <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end else begin
            r_clkcnt <= r_clkcnt + 16'd1;
          end
        end
        S_STOP: begin
          if (r_clkcnt == DIV_M1) begin
            r_clkcnt <= 16'd0;
            if (w_rxs) begin
              r_data   <= r_shift;
              r_push   <= 1'b1;
              r_state  <= S_IDLE;
              r_active <= 1'b0;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_clkcnt <= r_clkcnt + 16'd1;
          end
        end
        S_BREAK: begin
          r_clkcnt <= 16'd0;
          if (w_rxs) begin
            r_state  <= S_IDLE;
            r_active <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_clkcnt <= 16'd0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
